// File: rtl/mem_arbiter.sv
// Two-way arbiter sharing one block-wide main-memory port between the I-cache and D-cache.
// Owner signals are forwarded combinationally; RELEASE swallows the owner's one-cycle-late request drop.
module mem_arbiter #(
  parameter int ADDR_W    = 28,
  parameter int DATA_W    = 128,
  parameter int PRIO_MODE = 0
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              grant_d,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RELEASE} state_e;

  state_e state_q, state_d;
  logic   last_d_q, last_d_d;   // 1 when the D-cache owned the last completed transfer
  logic   grant_d_q, grant_d_d;
  logic   req_i, req_d, pick_d;

  assign req_i   = i_read | i_write;
  assign req_d   = d_read | d_write;
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;
  assign grant_d = grant_d_q;
  assign busy    = (state_q == BUSY_I) || (state_q == BUSY_D);

  // Tie-break out of IDLE: D wins alone, under fixed priority, or when I went last.
  assign pick_d = req_d && (!req_i || (PRIO_MODE == 1) || !last_d_q);

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state_q   <= IDLE;
      last_d_q  <= 1'b0;
      grant_d_q <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      last_d_q  <= last_d_d;
      grant_d_q <= grant_d_d;
    end
  end

  always_comb begin
    // NOTE: every output and next-state signal gets a default first, so no path infers a latch.
    state_d   = state_q;
    last_d_d  = last_d_q;
    grant_d_d = grant_d_q;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    i_ready   = 1'b0;
    d_ready   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_i || req_d) begin
          state_d   = pick_d ? BUSY_D : BUSY_I;
          grant_d_d = pick_d;
        end
      end
      BUSY_I: begin
        mem_read  = i_read;
        mem_write = i_write;
        mem_addr  = i_addr;
        mem_wdata = i_wdata;
        i_ready   = mem_ready;
        if (mem_ready) begin
          last_d_d = 1'b0;
          state_d  = RELEASE;
        end
      end
      BUSY_D: begin
        mem_read  = d_read;
        mem_write = d_write;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        d_ready   = mem_ready;
        if (mem_ready) begin
          last_d_d = 1'b1;
          state_d  = RELEASE;
        end
      end
      RELEASE: begin
        // The previous owner's request is stale here; only the other cache may be granted.
        if (last_d_q ? req_i : req_d) begin
          state_d   = last_d_q ? BUSY_I : BUSY_D;
          grant_d_d = !last_d_q;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
